// File: rtl/rtc_alarm.sv
//-----------------------------------------------------------------------------
// rtc_alarm
//
// Alarm controller sitting behind the real-time clock. Compares the RTC
// time {hh,mm} against a programmed alarm time and drives `ring`. Handles
// stop, snooze (with minute/hour wrap-around), and an automatic ring timeout
// that leaves a sticky `missed` flag behind.
//
// Build option:
//   RTC_ALARM_SNOOZE_EN - when defined, the SNOOZE state, snooze target
//                         arithmetic and snooze counter are compiled in.
//                         When undefined, the `snooze` port is ignored.
//
// Parameters:
//   RING_CYCLES - cycles `ring` stays high before auto-timeout
//   SNOOZE_MIN  - snooze length in minutes (1..59)
//   MAX_SNOOZE  - snoozes allowed per alarm event
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   hh, mm     in   current RTC time (0..23, 0..59)
//   alarm_hh   in   alarm hour to load
//   alarm_mm   in   alarm minute to load
//   alarm_set  in   one-cycle load strobe
//   alarm_en   in   level enable; 0 forces IDLE
//   stop       in   one-cycle dismiss strobe
//   snooze     in   one-cycle snooze strobe
//   ring       out  registered, high while ringing
//   armed      out  registered, high while waiting for alarm or snooze time
//   missed     out  sticky, set on ring timeout
//   set_err    out  one-cycle pulse after an out-of-range alarm_set
//   dbg_state  out  current FSM state (IDLE=0, ARMED=1, RINGING=2, SNOOZE=3)
//
// Handshake note: all strobes are sampled on the rising edge at which they
// are high; there is no back-pressure, every strobe is consumed in the cycle
// it is presented.
//-----------------------------------------------------------------------------
module rtc_alarm #(
   parameter int RING_CYCLES = 100,
   parameter int SNOOZE_MIN  = 5,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] hh,
   input  logic [5:0] mm,
   input  logic [4:0] alarm_hh,
   input  logic [5:0] alarm_mm,
   input  logic       alarm_set,
   input  logic       alarm_en,
   input  logic       stop,
   input  logic       snooze,
   output logic       ring,
   output logic       armed,
   output logic       missed,
   output logic       set_err,
   output logic [1:0] dbg_state
);

   localparam int CNT_W = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RINGING = 2'd2
`ifdef RTC_ALARM_SNOOZE_EN
      , ST_SNOOZE = 2'd3
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       alarm_hh_q, alarm_hh_d;
   logic [5:0]       alarm_mm_q, alarm_mm_d;
   logic [4:0]       prev_hh_q, prev_hh_d;
   logic [5:0]       prev_mm_q, prev_mm_d;
   logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
   logic             ring_q, ring_d;
   logic             armed_q, armed_d;
   logic             missed_q, missed_d;
   logic             set_err_q, set_err_d;

   logic             set_ok;
   logic             set_good;
   logic             set_bad;
   logic             time_new;
   logic             alarm_hit;

`ifdef RTC_ALARM_SNOOZE_EN
   localparam int SNZ_W = $clog2(MAX_SNOOZE + 1);
   localparam logic [SNZ_W-1:0] SNZ_MAX = SNZ_W'(MAX_SNOOZE);
   localparam logic [6:0]       SNZ_ADD = 7'(SNOOZE_MIN);

   logic [4:0]       snz_hh_q, snz_hh_d;
   logic [5:0]       snz_mm_q, snz_mm_d;
   logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
   logic [6:0]       snz_sum;
   logic [4:0]       snz_hh_n;
   logic [5:0]       snz_mm_n;
   logic             snz_hit;
`else
   // Port is kept for a stable interface but carries no function here.
   logic unused_snooze;
   assign unused_snooze = snooze;
`endif

   //--------------------------------------------------------------------------
   // Next-state and datapath
   //--------------------------------------------------------------------------
   always_comb begin
      // Event decode
      set_ok    = (alarm_hh <= 5'd23) && (alarm_mm <= 6'd59);
      set_good  = alarm_set & set_ok;
      set_bad   = alarm_set & ~set_ok;
      // A match only counts on the cycle the minute changes, so a held
      // matching time cannot re-trigger after stop/timeout.
      time_new  = ({hh, mm} != {prev_hh_q, prev_mm_q});
      alarm_hit = ({hh, mm} == {alarm_hh_q, alarm_mm_q}) && time_new;

`ifdef RTC_ALARM_SNOOZE_EN
      snz_hit = ({hh, mm} == {snz_hh_q, snz_mm_q}) && time_new;
      // Snooze target = now + SNOOZE_MIN with minute carry into the hour
      // and 23 -> 0 hour wrap. SNOOZE_MIN <= 59 keeps the carry to one.
      snz_sum = {1'b0, mm} + SNZ_ADD;
      if (snz_sum >= 7'd60) begin
         snz_mm_n = 6'(snz_sum - 7'd60);
         snz_hh_n = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
      end else begin
         snz_mm_n = snz_sum[5:0];
         snz_hh_n = hh;
      end
      snz_hh_d  = snz_hh_q;
      snz_mm_d  = snz_mm_q;
      snz_cnt_d = snz_cnt_q;
`endif

      // Defaults: hold everything, sample time every cycle
      state_d    = state_q;
      alarm_hh_d = alarm_hh_q;
      alarm_mm_d = alarm_mm_q;
      prev_hh_d  = hh;
      prev_mm_d  = mm;
      ring_cnt_d = ring_cnt_q;
      missed_d   = missed_q;
      set_err_d  = set_bad;

      // Register effects of alarm_set / stop apply regardless of alarm_en;
      // alarm_en only governs where the FSM goes.
      if (set_good) begin
         alarm_hh_d = alarm_hh;
         alarm_mm_d = alarm_mm;
         missed_d   = 1'b0;
`ifdef RTC_ALARM_SNOOZE_EN
         snz_cnt_d  = '0;
`endif
      end else if (!set_bad && stop) begin
         missed_d = 1'b0;
      end

      if (!alarm_en) begin
         state_d    = ST_IDLE;
         ring_cnt_d = '0;
`ifdef RTC_ALARM_SNOOZE_EN
         snz_cnt_d  = '0;
`endif
      end else if (set_bad) begin
         // Rejected load freezes the FSM and ring counter for this cycle.
         state_d = state_q;
      end else if (set_good) begin
         state_d    = ST_ARMED;
         ring_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARMED;
            end
            ST_ARMED: begin
               if (alarm_hit) begin
                  state_d    = ST_RINGING;
                  ring_cnt_d = '0;
               end
            end
            ST_RINGING: begin
               if (stop) begin
                  state_d    = ST_ARMED;
                  ring_cnt_d = '0;
`ifdef RTC_ALARM_SNOOZE_EN
                  snz_cnt_d  = '0;
               end else if (snooze) begin
                  ring_cnt_d = '0;
                  if (snz_cnt_q < SNZ_MAX) begin
                     state_d   = ST_SNOOZE;
                     snz_hh_d  = snz_hh_n;
                     snz_mm_d  = snz_mm_n;
                     snz_cnt_d = snz_cnt_q + 1'b1;
                  end else begin
                     // Snoozes exhausted: behaves exactly like stop.
                     state_d   = ST_ARMED;
                     snz_cnt_d = '0;
                     missed_d  = 1'b0;
                  end
`endif
               end else if (ring_cnt_q == RING_LAST) begin
                  state_d    = ST_ARMED;
                  ring_cnt_d = '0;
                  missed_d   = 1'b1;
`ifdef RTC_ALARM_SNOOZE_EN
                  snz_cnt_d  = '0;
`endif
               end else begin
                  ring_cnt_d = ring_cnt_q + 1'b1;
               end
            end
`ifdef RTC_ALARM_SNOOZE_EN
            ST_SNOOZE: begin
               if (snz_hit) begin
                  state_d    = ST_RINGING;
                  ring_cnt_d = '0;
               end
            end
`endif
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Outputs are registered copies of the state being entered.
      ring_d  = (state_d == ST_RINGING);
`ifdef RTC_ALARM_SNOOZE_EN
      armed_d = (state_d == ST_ARMED) || (state_d == ST_SNOOZE);
`else
      armed_d = (state_d == ST_ARMED);
`endif
   end

   //--------------------------------------------------------------------------
   // State registers
   //--------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         alarm_hh_q <= '0;
         alarm_mm_q <= '0;
         prev_hh_q  <= '0;
         prev_mm_q  <= '0;
         ring_cnt_q <= '0;
         ring_q     <= 1'b0;
         armed_q    <= 1'b0;
         missed_q   <= 1'b0;
         set_err_q  <= 1'b0;
`ifdef RTC_ALARM_SNOOZE_EN
         snz_hh_q   <= '0;
         snz_mm_q   <= '0;
         snz_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         alarm_hh_q <= alarm_hh_d;
         alarm_mm_q <= alarm_mm_d;
         prev_hh_q  <= prev_hh_d;
         prev_mm_q  <= prev_mm_d;
         ring_cnt_q <= ring_cnt_d;
         ring_q     <= ring_d;
         armed_q    <= armed_d;
         missed_q   <= missed_d;
         set_err_q  <= set_err_d;
`ifdef RTC_ALARM_SNOOZE_EN
         snz_hh_q   <= snz_hh_d;
         snz_mm_q   <= snz_mm_d;
         snz_cnt_q  <= snz_cnt_d;
`endif
      end
   end

   assign ring      = ring_q;
   assign armed     = armed_q;
   assign missed    = missed_q;
   assign set_err   = set_err_q;
   assign dbg_state = state_q;

endmodule

// File: doc/rtc_alarm.md
# rtc_alarm

Alarm controller placed directly downstream of the real-time clock. It consumes the clock's `hh`/`mm` time outputs, compares them against a programmed alarm time, and drives a `ring` output. The block handles stop, snooze with minute/hour wrap-around, and a ring timeout. It feeds the buzzer/LED driver and the status display.

## Interface
- `RING_CYCLES`, 100: number of clock cycles `ring` stays high before auto-timeout.
- `SNOOZE_MIN`, 5: snooze length in minutes; legal range 1..59.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event; once exhausted, `snooze` behaves as `stop`.

- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hh`  in  5  current hour from the RTC, 0..23.
- `mm`  in  6  current minute from the RTC, 0..59.
- `alarm_hh`  in  5  alarm hour to load.
- `alarm_mm`  in  6  alarm minute to load.
- `alarm_set`  in  1  one-cycle load strobe for `alarm_hh`/`alarm_mm`.
- `alarm_en`  in  1  level; 0 forces the block to IDLE.
- `stop`  in  1  one-cycle strobe; dismisses the alarm.
- `snooze`  in  1  one-cycle strobe; postpones the alarm by `SNOOZE_MIN`.
- `ring`  out  1  registered; high while ringing.
- `armed`  out  1  registered; high in ARMED or SNOOZE.
- `missed`  out  1  sticky; set on ring timeout, cleared by `stop` or `alarm_set`.
- `set_err`  out  1  one-cycle pulse when `alarm_set` carries an out-of-range value.

## Operation
- States:
  - IDLE: `alarm_en`=0.
  - ARMED: target = programmed alarm.
  - RINGING.
  - SNOOZE: target = snooze time.
- `prev_time` register samples {`hh`,`mm`} every cycle.
- Match event = ({`hh`,`mm`} == target) AND ({`hh`,`mm`} != `prev_time`). An alarm fires only on entry into the matching minute, never on a held match.
- `alarm_set` with `alarm_hh`≤23 and `alarm_mm`≤59:
  - loads the alarm registers and clears the snooze count and `missed`;
  - from RINGING or SNOOZE, goes to ARMED if `alarm_en`=1.
- `alarm_set` with an out-of-range value: registers unchanged, state unchanged, `set_err` pulses.
- IDLE → ARMED when `alarm_en`=1.
- ARMED or SNOOZE → RINGING on a match event. The ring counter loads 0.
- RINGING transitions:
  - `stop` → ARMED; snooze count cleared.
  - `snooze` with snooze count < `MAX_SNOOZE` → SNOOZE. Snooze target = current {`hh`,`mm`} + `SNOOZE_MIN`. Minute sum ≥60 subtracts 60 and increments the hour; hour 23 wraps to 0. Snooze count increments.
  - `snooze` with snooze count = `MAX_SNOOZE` → treated as `stop`.
  - Ring counter reaching `RING_CYCLES`-1 → ARMED; `missed` set; snooze count cleared.
- Priority, highest first: `rst` > `alarm_en`=0 > `alarm_set` > `stop` > `snooze` > timeout > match event.
- `alarm_en`=0 from any state → IDLE next cycle. `ring` and `armed` go low; alarm registers are kept.
- Width rules:
  - snooze minute sum computed in 7 bits;
  - ring counter sized to $clog2(`RING_CYCLES`);
  - snooze count sized to $clog2(`MAX_SNOOZE`+1).

## Timing
- Reset values:
  - state IDLE;
  - `ring`, `armed`, `missed`, `set_err` all 0;
  - alarm registers 00:00;
  - `prev_time` 00:00;
  - counters 0.
- Because `prev_time` resets to 00:00, a time of 00:00 held from reset does not fire.
- Match latency: {`hh`,`mm`} changes at edge N; `ring` is high after edge N+1.
- `stop`/`snooze` sampled at edge N: `ring` is low after edge N.
- `ring` high for exactly `RING_CYCLES` cycles on timeout; `missed` rises in the same cycle `ring` falls.
- `set_err` is high for the single cycle after the offending `alarm_set` edge.
- `rst` asserted mid-ring: all outputs return to reset values at the next edge.

## Configuration
- `RTC_ALARM_SNOOZE_EN` defined: snooze logic, the SNOOZE state and the snooze counter are compiled in, as described above.
- `RTC_ALARM_SNOOZE_EN` undefined:
  - the `snooze` port remains but is ignored;
  - the SNOOZE state and snooze arithmetic are absent;
  - RINGING exits only via `stop`, timeout, `alarm_set` or `alarm_en`=0.

## Test plan
- Basic fire: alarm 07:30, `alarm_en`=1, time steps 07:29→07:30 → `ring`=1 one cycle later. `stop` → `ring`=0 and `armed`=1. Time held at 07:30 → no re-ring.
- Snooze wrap: alarm 23:57, `SNOOZE_MIN`=5, `snooze` pulsed at 23:57 → SNOOZE state with target 00:02. Time reaches 00:02 → `ring`=1.
- Snooze exhaustion: `MAX_SNOOZE`=3; after 3 snoozes, 4th `snooze` → ARMED, `ring`=0, count cleared. Next day 07:30 rings again.
- Timeout: `RING_CYCLES`=100, no response → `ring` high exactly 100 cycles, then `missed`=1 and `armed`=1. `stop` clears `missed`.
- Conflicts: `stop`+`snooze` same cycle → ARMED, not SNOOZE. `alarm_set` with `alarm_mm`=60 → `set_err` pulse, old alarm kept. `alarm_en`=0 during RINGING → IDLE next cycle.
- Reset: `rst` mid-ring → `ring`=0, alarm 00:00, IDLE. With `RTC_ALARM_SNOOZE_EN` undefined, `snooze` during RINGING has no effect.
